mc_control_fsm_hs: RTL and testbench
====================================

// Module: mc_control_fsm_hs
// PURPOSE
//  Parametrised multi-cycle MIPS control FSM with handshaked instruction/data memory (req/ready wait states).
//  Sequences IF/ID/EX/MEM/WB; adds slt, an illegal-instruction trap, a memory-timeout trap and explicit PC/IR write strobes.
//  Sits between the instruction register/PC and the datapath muxes, ALU, register file and data memory.
// PARAMETERS
//  INSTR_LEN       32  instruction width; opcode = [31:26], funct = [5:0]
//  ALU_OP_W        4   width of alu_op
//  TIMEOUT_CYCLES  16  maximum wait cycles in IF/MEM before the timeout trap; 0 = never time out
//  CNT_W           5   wait-counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          reset, asynchronous, active-high
//  inst           in   INSTR_LEN  instruction memory read data
//  imem_ready     in   1          instruction memory has valid inst this cycle
//  dmem_ready     in   1          data memory access completes this cycle
//  zero           in   1          ALU zero flag (valid in EX)
//  trap_clear     in   1          leave TRAP, resume at IF
//  imem_req       out  1          instruction fetch request
//  dmem_req       out  1          data memory request
//  ir_write       out  1          latch inst into the IR
//  pc_write       out  1          PC update strobe; source chosen by branch_flag/jump_flag
//  reg_dst_flag   out  1          1 = rd, 0 = rt
//  alu_src_flag   out  1          1 = sign-/zero-extended immediate
//  mem_to_reg_flag out 1          write-back from memory
//  reg_write_flag out  1          register file write enable
//  mem_read_flag  out  1          data memory read
//  mem_write_flag out  1          data memory write
//  branch_flag    out  1          beq PC select
//  jump_flag      out  1          j PC select
//  alu_op         out  ALU_OP_W   ALU operation
//  state          out  3          current state encoding
//  illegal_trap   out  1          sticky: unknown opcode/funct decoded
//  timeout_trap   out  1          sticky: memory wait exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (async)
//   - state = IF; internal IR = 0; wait counter = 0; both trap flags = 0.
//   - All strobes are 0 and alu_op = ALU_NOP.
//   - An asserted rst overrides any state, including a pending wait.
//  Supported opcodes
//   - R-type (000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
//   - addi 001000, ori 001101, beq 000100, j 000010, lw 100011, sw 101011.
//  Decode
//   - Decode is taken from the internal IR, not from inst.
//   - reg_dst_flag, alu_src_flag, alu_op and mem_to_reg_flag (lw only) are driven from decode in ID, EX, MEM and WB.
//   - These signals are 0 / ALU_NOP in IF and TRAP.
//  IF
//   - imem_req = 1.
//   - When imem_ready = 1: ir_write = 1, pc_write = 1 (PC+4), IR <= inst, next state ID.
//   - Otherwise stay in IF.
//  ID
//   - If the opcode or funct is illegal: illegal_trap <= 1, next state TRAP.
//   - Otherwise next state EX.
//  EX
//   - beq: branch_flag = 1, pc_write = zero, next IF.
//   - j: jump_flag = 1, pc_write = 1, next IF.
//   - lw/sw: next MEM.
//   - R-type/addi/ori: next WB.
//  MEM
//   - dmem_req = 1; mem_read_flag (lw) or mem_write_flag (sw) is held until dmem_ready.
//   - On dmem_ready: lw goes to WB, sw goes to IF.
//  WB
//   - reg_write_flag = 1 for exactly one cycle; mem_to_reg_flag = 1 for lw; next IF.
//  Wait counter
//   - Counts consecutive cycles in IF or MEM without the matching ready; cleared on every state change.
//   - If TIMEOUT_CYCLES > 0 and count == TIMEOUT_CYCLES-1 with ready still low: timeout_trap <= 1, next TRAP.
//   - Ready arriving in that same cycle wins: no trap.
//  TRAP
//   - All strobes are 0, no requests, state held.
//   - trap_clear = 1 clears both flags and goes to IF.
//  Latency
//   - Zero wait states: beq/j take 3 cycles, R/addi/ori/sw take 4, lw takes 5.
//   - Each wait cycle adds 1.
//  Output timing
//   - All outputs are combinational functions of state, IR, counter and inputs (Moore except ready/zero qualification).
//   - No output depends on inst except through the IR.
//  Encodings
//   - State: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5; codes 6/7 recover to IF on the next edge.
// STRUCTURE
//  - Package mc_ctrl_pkg: opcode/funct localparams, ALU codes (NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5), state encodings.
//  - Sub-module mc_main_decoder: combinational IR -> {reg_dst, alu_src, mem_to_reg, alu_op, is_*, illegal}.
//  - Top module: FSM, IR register, wait counter, trap flags, phase gating of strobes.
// TESTING
//  1. add $3,$1,$2 (0x00221820), imem_ready=1 at once: ID/EX/WB follow; reg_dst=1; alu_op=ADD in EX; one reg_write pulse in cycle 4.
//  2. lw 0x8C220004 with dmem_ready low for 3 MEM cycles: mem_read held 4 cycles, then WB with mem_to_reg=1 and reg_write=1; total 8 cycles.
//  3. beq 0x10220003: zero=1 -> pc_write=1, branch=1 in EX; zero=0 -> pc_write=0; both cases return to IF next cycle.
//  4. Opcode 0x3F: illegal_trap=1, state=5, all strobes 0; trap_clear pulse -> state=0, flag cleared.
//  5. TIMEOUT_CYCLES=4, imem_ready never asserted: timeout_trap=1 after exactly 4 IF cycles; with ready in the 4th cycle there is no trap.
//  6. Assert rst in mid-MEM of sw: mem_write drops immediately, state=0, IR=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | mc_ctrl_pkg : shared encodings for the multi-cycle MIPS control FSM (r1.0)   |
// +----------------------------------------------------------------------------+
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_TRAP = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam int ALU_NOP = 0;
  localparam int ALU_ADD = 1;
  localparam int ALU_SUB = 2;
  localparam int ALU_AND = 3;
  localparam int ALU_OR  = 4;
  localparam int ALU_SLT = 5;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic is_beq;
    logic is_j;
    logic is_lw;
    logic is_sw;
    logic illegal;
  } dec_t;

endpackage

`default_nettype wire

// File: rtl/mc_main_decoder.sv
// +----------------------------------------------------------------------------+
// | mc_main_decoder : opcode/funct -> datapath controls and class flags (r1.0)   |
// +----------------------------------------------------------------------------+
`default_nettype none

module mc_main_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output dec_t                dec,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    dec    = '0;
    alu_op = ALU_OP_W'(ALU_NOP);
    case (opcode)
      OP_RTYPE: begin
        dec.reg_dst = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_OP_W'(ALU_ADD);
          FN_SUB:  alu_op = ALU_OP_W'(ALU_SUB);
          FN_AND:  alu_op = ALU_OP_W'(ALU_AND);
          FN_OR:   alu_op = ALU_OP_W'(ALU_OR);
          FN_SLT:  alu_op = ALU_OP_W'(ALU_SLT);
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec.alu_src = 1'b1;
        alu_op      = ALU_OP_W'(ALU_ADD);
      end
      OP_ORI: begin
        dec.alu_src = 1'b1;
        alu_op      = ALU_OP_W'(ALU_OR);
      end
      OP_BEQ: begin
        dec.is_beq = 1'b1;
        alu_op     = ALU_OP_W'(ALU_SUB);
      end
      OP_J: dec.is_j = 1'b1;
      OP_LW: begin
        dec.is_lw      = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        alu_op         = ALU_OP_W'(ALU_ADD);
      end
      OP_SW: begin
        dec.is_sw   = 1'b1;
        dec.alu_src = 1'b1;
        alu_op      = ALU_OP_W'(ALU_ADD);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm_hs.sv
// +----------------------------------------------------------------------------+
// | mc_control_fsm_hs : handshaked multi-cycle MIPS control FSM with traps (r1.0)|
// +----------------------------------------------------------------------------+
`default_nettype none

module mc_control_fsm_hs
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_LEN      = 32,
  parameter int ALU_OP_W       = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_LEN-1:0] inst,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 zero,
  input  logic                 trap_clear,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_dst_flag,
  output logic                 alu_src_flag,
  output logic                 mem_to_reg_flag,
  output logic                 reg_write_flag,
  output logic                 mem_read_flag,
  output logic                 mem_write_flag,
  output logic                 branch_flag,
  output logic                 jump_flag,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic [2:0]           state,
  output logic                 illegal_trap,
  output logic                 timeout_trap
);

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t                 state_q, state_d;
  logic [INSTR_LEN-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   illegal_q, illegal_d;
  logic                   timeout_q, timeout_d;

  dec_t                   dec;
  logic [ALU_OP_W-1:0]    dec_alu_op;
  logic                   dec_phase;
  logic                   to_hit;
  logic                   unused_ir_bits;

  mc_main_decoder #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .opcode (ir_q[INSTR_LEN-1:INSTR_LEN-6]),
    .funct  (ir_q[5:0]),
    .dec    (dec),
    .alu_op (dec_alu_op)
  );

  assign unused_ir_bits = ^ir_q[INSTR_LEN-7:6];
  assign to_hit         = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IF;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    cnt_d          = '0;
    illegal_d      = illegal_q;
    timeout_d      = timeout_q;
    dec_phase      = 1'b0;
    imem_req       = 1'b0;
    dmem_req       = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    reg_write_flag = 1'b0;
    mem_read_flag  = 1'b0;
    mem_write_flag = 1'b0;
    branch_flag    = 1'b0;
    jump_flag      = 1'b0;
    case (state_q)
      ST_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          ir_d     = inst;
          state_d  = ST_ID;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ID: begin
        dec_phase = 1'b1;
        if (dec.illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        dec_phase = 1'b1;
        if (dec.is_beq) begin
          branch_flag = 1'b1;
          pc_write    = zero;
          state_d     = ST_IF;
        end else if (dec.is_j) begin
          jump_flag = 1'b1;
          pc_write  = 1'b1;
          state_d   = ST_IF;
        end else if (dec.is_lw || dec.is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dec_phase      = 1'b1;
        dmem_req       = 1'b1;
        mem_read_flag  = dec.is_lw;
        mem_write_flag = dec.is_sw;
        if (dmem_ready) begin
          state_d = dec.is_lw ? ST_WB : ST_IF;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WB: begin
        dec_phase      = 1'b1;
        reg_write_flag = 1'b1;
        state_d        = ST_IF;
      end
      ST_TRAP: begin
        if (trap_clear) begin
          illegal_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_IF;
        end
      end
      default: state_d = ST_IF;
    endcase

    reg_dst_flag    = dec_phase & dec.reg_dst;
    alu_src_flag    = dec_phase & dec.alu_src;
    mem_to_reg_flag = dec_phase & dec.mem_to_reg;
    alu_op          = dec_phase ? dec_alu_op : ALU_OP_W'(ALU_NOP);

    // Reset is asynchronous, so outputs must fall in the same cycle it rises.
    if (rst) begin
      imem_req        = 1'b0;
      dmem_req        = 1'b0;
      ir_write        = 1'b0;
      pc_write        = 1'b0;
      reg_dst_flag    = 1'b0;
      alu_src_flag    = 1'b0;
      mem_to_reg_flag = 1'b0;
      reg_write_flag  = 1'b0;
      mem_read_flag   = 1'b0;
      mem_write_flag  = 1'b0;
      branch_flag     = 1'b0;
      jump_flag       = 1'b0;
      alu_op          = ALU_OP_W'(ALU_NOP);
    end
  end

  assign state        = state_q;
  assign illegal_trap = illegal_q;
  assign timeout_trap = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm_hs.sv
// +----------------------------------------------------------------------------+
// | tb_mc_control_fsm_hs : directed bench for mc_control_fsm_hs (r1.0)           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mc_control_fsm_hs;

  localparam logic [11:0] IMQ  = 12'h800;
  localparam logic [11:0] DMQ  = 12'h400;
  localparam logic [11:0] IRW  = 12'h200;
  localparam logic [11:0] PCW  = 12'h100;
  localparam logic [11:0] RDST = 12'h080;
  localparam logic [11:0] ASRC = 12'h040;
  localparam logic [11:0] M2R  = 12'h020;
  localparam logic [11:0] RW   = 12'h010;
  localparam logic [11:0] MR   = 12'h008;
  localparam logic [11:0] MW   = 12'h004;
  localparam logic [11:0] BR   = 12'h002;
  localparam logic [11:0] JP   = 12'h001;

  logic        clk, rst;
  logic [31:0] inst;
  logic        imem_ready, dmem_ready, zero, trap_clear;
  logic        imem_req, dmem_req, ir_write, pc_write;
  logic        reg_dst_flag, alu_src_flag, mem_to_reg_flag, reg_write_flag;
  logic        mem_read_flag, mem_write_flag, branch_flag, jump_flag;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic        illegal_trap, timeout_trap;

  int checks   = 0;
  int failures = 0;
  logic [20:0] exp_v;
  logic [20:0] obs;

  mc_control_fsm_hs #(
    .INSTR_LEN(32), .ALU_OP_W(4), .TIMEOUT_CYCLES(4), .CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .inst(inst), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .zero(zero), .trap_clear(trap_clear),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .reg_dst_flag(reg_dst_flag), .alu_src_flag(alu_src_flag),
    .mem_to_reg_flag(mem_to_reg_flag), .reg_write_flag(reg_write_flag),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .branch_flag(branch_flag), .jump_flag(jump_flag), .alu_op(alu_op),
    .state(state), .illegal_trap(illegal_trap), .timeout_trap(timeout_trap)
  );

  assign obs = {state, alu_op, imem_req, dmem_req, ir_write, pc_write, reg_dst_flag,
                alu_src_flag, mem_to_reg_flag, reg_write_flag, mem_read_flag,
                mem_write_flag, branch_flag, jump_flag, illegal_trap, timeout_trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] ev(input logic [2:0] st, input logic [3:0] alu,
                                     input logic [11:0] s, input logic il, input logic to);
    return {st, alu, s, il, to};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #4;
  endtask

  task automatic test_reset;
    rst = 1'b1; inst = 32'hFFFF_FFFF; imem_ready = 1'b1; dmem_ready = 1'b0;
    zero = 1'b0; trap_clear = 1'b0;
    tick; settle;
    exp_v = ev(3'd0, 4'd0, 12'h000, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, exp_v); end
    tick;
    rst = 1'b0; imem_ready = 1'b0;
    settle;
    exp_v = ev(3'd0, 4'd0, IMQ, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_release_if got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_add;
    logic [20:0] exp_seq [4];
    exp_seq[0] = ev(3'd0, 4'd0, IMQ | IRW | PCW, 1'b0, 1'b0);
    exp_seq[1] = ev(3'd1, 4'd1, RDST, 1'b0, 1'b0);
    exp_seq[2] = ev(3'd2, 4'd1, RDST, 1'b0, 1'b0);
    exp_seq[3] = ev(3'd4, 4'd1, RDST | RW, 1'b0, 1'b0);
    inst = 32'h0022_1820; imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle;
      checks++;
      if (obs !== exp_seq[i]) begin failures++; $display("FAIL add_cycle%0d got=%h exp=%h", i + 1, obs, exp_seq[i]); end
      tick;
      imem_ready = 1'b0;
    end
    settle;
    exp_v = ev(3'd0, 4'd0, IMQ, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL add_back_to_if got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_lw_wait;
    int cyc = 0;
    inst = 32'h8C22_0004; imem_ready = 1'b1;
    settle;
    exp_v = ev(3'd0, 4'd0, IMQ | IRW | PCW, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL lw_fetch got=%h exp=%h", obs, exp_v); end
    tick; cyc++; imem_ready = 1'b0; inst = 32'hFFFF_FFFF;
    settle;
    exp_v = ev(3'd1, 4'd1, ASRC | M2R, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL lw_id got=%h exp=%h", obs, exp_v); end
    tick; cyc++;
    tick; cyc++;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      settle;
      exp_v = ev(3'd3, 4'd1, DMQ | ASRC | M2R | MR, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL lw_mem%0d got=%h exp=%h", i, obs, exp_v); end
      tick; cyc++;
    end
    dmem_ready = 1'b0;
    settle;
    exp_v = ev(3'd4, 4'd1, ASRC | M2R | RW, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL lw_wb got=%h exp=%h", obs, exp_v); end
    tick; cyc++;
    settle;
    checks++;
    if (state !== 3'd0 || cyc !== 8) begin
      failures++; $display("FAIL lw_latency state=%0d cycles=%0d exp_state=0 exp_cycles=8", state, cyc);
    end
  endtask

  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      inst = 32'h1022_0003; imem_ready = 1'b1;
      settle;
      exp_v = ev(3'd0, 4'd0, IMQ | IRW | PCW, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL beq_fetch_z%0d got=%h exp=%h", z, obs, exp_v); end
      tick; imem_ready = 1'b0;
      settle;
      exp_v = ev(3'd1, 4'd2, 12'h000, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL beq_id_z%0d got=%h exp=%h", z, obs, exp_v); end
      tick; zero = z[0];
      settle;
      exp_v = ev(3'd2, 4'd2, BR | (z[0] ? PCW : 12'h000), 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL beq_ex_z%0d got=%h exp=%h", z, obs, exp_v); end
      tick; zero = 1'b0;
    end
    settle;
    exp_v = ev(3'd0, 4'd0, IMQ, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL beq_back_to_if got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_illegal;
    inst = 32'hFC00_0000; imem_ready = 1'b1;
    tick; imem_ready = 1'b0;
    settle;
    exp_v = ev(3'd1, 4'd0, 12'h000, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL illegal_id got=%h exp=%h", obs, exp_v); end
    tick; tick;
    settle;
    exp_v = ev(3'd5, 4'd0, 12'h000, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL illegal_trap_hold got=%h exp=%h", obs, exp_v); end
    tick; trap_clear = 1'b1;
    tick; trap_clear = 1'b0;
    settle;
    exp_v = ev(3'd0, 4'd0, IMQ, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL illegal_clear got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 4; i++) begin
      settle;
      exp_v = ev(3'd0, 4'd0, IMQ, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL timeout_wait%0d got=%h exp=%h", i, obs, exp_v); end
      tick;
    end
    settle;
    exp_v = ev(3'd5, 4'd0, 12'h000, 1'b0, 1'b1);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL timeout_trap got=%h exp=%h", obs, exp_v); end
    trap_clear = 1'b1;
    tick; trap_clear = 1'b0;
    tick; tick; tick;
    inst = 32'h0800_0000; imem_ready = 1'b1;
    settle;
    exp_v = ev(3'd0, 4'd0, IMQ | IRW | PCW, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL timeout_ready_last got=%h exp=%h", obs, exp_v); end
    tick; imem_ready = 1'b0;
    tick;
    settle;
    exp_v = ev(3'd2, 4'd0, JP | PCW, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL jump_ex got=%h exp=%h", obs, exp_v); end
    tick;
  endtask

  task automatic test_reset_mid_mem;
    inst = 32'hAC22_0004; imem_ready = 1'b1;
    tick; imem_ready = 1'b0;
    tick; tick;
    settle;
    exp_v = ev(3'd3, 4'd1, DMQ | ASRC | MW, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL sw_mem got=%h exp=%h", obs, exp_v); end
    rst = 1'b1;
    #1;
    exp_v = ev(3'd0, 4'd0, 12'h000, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL sw_async_reset got=%h exp=%h", obs, exp_v); end
    tick; rst = 1'b0;
    settle;
    checks++;
    if (dut.ir_q !== 32'h0 || state !== 3'd0) begin
      failures++; $display("FAIL sw_reset_ir ir=%h state=%0d exp_ir=0 exp_state=0", dut.ir_q, state);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_lw_wait;
    test_beq;
    test_illegal;
    test_timeout;
    test_reset_mid_mem;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
